// File: rtl/digital_io_pkg.sv
// digital_io_pkg: register offsets and reset constants for digital_io_control
package digital_io_pkg;
    localparam int DIO_OFS_W = 8;
    localparam logic [DIO_OFS_W-1:0] DIO_OUT_OFS  = 8'h00;
    localparam logic [DIO_OFS_W-1:0] DIO_OEB_OFS  = 8'h04;
    localparam logic [DIO_OFS_W-1:0] DIO_IN_OFS   = 8'h08;
    localparam logic [DIO_OFS_W-1:0] DIO_EDGE_OFS = 8'h0C;
    localparam logic [DIO_OFS_W-1:0] DIO_MASK_OFS = 8'h10;
    localparam logic [7:0] DIO_OEB_RST = 8'hFF;
endpackage

// File: rtl/dio_input_sync.sv
// dio_input_sync: 2-flop pad synchronizer, plus stage-3 rising-edge pulse when DIGITAL_IO_EDGE_IRQ_EN is defined
module dio_input_sync #(
    parameter int BITS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] din,
    output logic [BITS-1:0] sync_o,
    output logic [BITS-1:0] rise_o
);
    logic [BITS-1:0] s1, s2;

    // two-stage metastability filter on the asynchronous pad levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    assign sync_o = s2;

`ifdef DIGITAL_IO_EDGE_IRQ_EN
    logic [BITS-1:0] s3;

    // delayed copy of the synchronized level for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) s3 <= '0;
        else        s3 <= s2;
    end

    assign rise_o = s2 & ~s3;
`else
    assign rise_o = '0;
`endif
endmodule

// File: rtl/digital_io_control.sv
// digital_io_control: Wishbone register block for digital pads; DIGITAL_IO_EDGE_IRQ_EN adds EDGE/MASK and irq
module digital_io_control
    import digital_io_pkg::*;
#(
    parameter int          BITS     = 6,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
`ifdef USE_POWER_PINS
    inout  wire             vccd1,
    inout  wire             vssd1,
`endif
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] io_in,
    output logic [BITS-1:0] io_out,
    output logic [BITS-1:0] io_oeb,
    output logic            irq
);
    logic [BITS-1:0]      in_sync, rise, rdata, wdat;
    logic [DIO_OFS_W-1:0] ofs;
    logic                 accept, wr;

    assign ofs    = wbs_adr_i[DIO_OFS_W-1:0];
    assign wdat   = wbs_dat_i[BITS-1:0];
    assign accept = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wr     = accept & wbs_we_i & wbs_sel_i[0];

    dio_input_sync #(.BITS(BITS)) u_sync (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .din    (io_in),
        .sync_o (in_sync),
        .rise_o (rise)
    );

`ifdef DIGITAL_IO_EDGE_IRQ_EN
    logic [BITS-1:0] edge_q, mask_q, clr;

    assign clr = (wr && ofs == DIO_EDGE_OFS) ? wdat : '0;

    // sticky edge flags: a new rise beats a same-cycle W1C clear
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            edge_q <= '0;
            mask_q <= '0;
        end else begin
            edge_q <= (edge_q & ~clr) | rise;
            if (wr && ofs == DIO_MASK_OFS) mask_q <= wdat;
        end
    end

    assign irq = |(edge_q & mask_q);

    // read mux over current register contents
    always_comb begin
        rdata = ofs == DIO_OUT_OFS  ? io_out  :
                ofs == DIO_OEB_OFS  ? io_oeb  :
                ofs == DIO_IN_OFS   ? in_sync :
                ofs == DIO_EDGE_OFS ? edge_q  :
                ofs == DIO_MASK_OFS ? mask_q  : '0;
    end

    logic unused;
    assign unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:BITS]};
`else
    assign irq = 1'b0;

    // read mux over current register contents; EDGE/MASK read as unmapped
    always_comb begin
        rdata = ofs == DIO_OUT_OFS ? io_out  :
                ofs == DIO_OEB_OFS ? io_oeb  :
                ofs == DIO_IN_OFS  ? in_sync : '0;
    end

    logic unused;
    assign unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:BITS], rise};
`endif

    // single-cycle registered ack, read data and pad control registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            io_out    <= '0;
            io_oeb    <= DIO_OEB_RST[BITS-1:0];
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept & ~wbs_we_i) ? {{(32-BITS){1'b0}}, rdata} : '0;
            if (wr && ofs == DIO_OUT_OFS) io_out <= wdat;
            if (wr && ofs == DIO_OEB_OFS) io_oeb <= wdat;
        end
    end
endmodule
